// File: rtl/stack_op_sequencer.sv
// Turns PUSH/POP/CALL/RET requests into single-port stack-RAM accesses.
// Also owns the downward-growing stack pointer and the depth count.
module stack_op_sequencer #(
  parameter int              DW      = 8,
  parameter int              AW      = 8,
  parameter logic [AW-1:0]   SP_INIT = '1,
  parameter int              DEPTH   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          op_valid,
  input  logic [1:0]    op,
  output logic          op_ready,
  input  logic [DW-1:0] r0,
  input  logic [DW-1:0] pc_ret,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic          mem_re,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] pop_data,
  output logic          pc_load,
  output logic [AW-1:0] sp,
  output logic          empty,
  output logic          full
);

  typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, FIN} state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  state_t        state;
  logic [AW:0]   count;
  logic [DW-1:0] data_q;
  logic          ret_q;

  // NOTE: every register here is written with <= so all reads in this block
  // see the pre-edge value; blocking assignments would create ordering bugs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sp        <= SP_INIT;
      count     <= '0;
      op_ready  <= 1'b1;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      pc_load   <= 1'b0;
      pop_data  <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      data_q    <= '0;
      ret_q     <= 1'b0;
    end else begin
      // Strobes are single-cycle pulses unless a state below raises them.
      mem_we  <= 1'b0;
      mem_re  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      pc_load <= 1'b0;

      unique case (state)
        IDLE: begin
          if (op_valid) begin
            op_ready <= 1'b0;
            data_q   <= op[1] ? pc_ret : r0;
            ret_q    <= (op == 2'b11);
            state    <= op[0] ? RD : WR;
          end
        end

        WR: begin
          done     <= 1'b1;
          op_ready <= 1'b1;
          state    <= IDLE;
          if (full) begin
            err <= 1'b1;
          end else begin
            mem_we    <= 1'b1;
            mem_addr  <= sp;
            mem_wdata <= data_q;
            sp        <= sp - 1'b1;
            count     <= count + ONE_C;
            empty     <= 1'b0;
            full      <= (count + ONE_C == DEPTH_C);
          end
        end

        RD: begin
          if (empty) begin
            done     <= 1'b1;
            err      <= 1'b1;
            op_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            mem_re   <= 1'b1;
            mem_addr <= sp + 1'b1;
            sp       <= sp + 1'b1;
            count    <= count - ONE_C;
            full     <= 1'b0;
            empty    <= (count == ONE_C);
            state    <= RWAIT;
          end
        end

        // RAM registers its read data on this edge; it is sampled in FIN.
        RWAIT: state <= FIN;

        FIN: begin
          done     <= 1'b1;
          pop_data <= mem_rdata;
          pc_load  <= ret_q;
          op_ready <= 1'b1;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Directed bench for stack_op_sequencer with a behavioural single-port stack RAM.
module tb_stack_op_sequencer;

  localparam logic [1:0] OP_PUSH = 2'b00, OP_POP = 2'b01, OP_CALL = 2'b10, OP_RET = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       op_valid = 1'b0;
  logic [1:0] op = '0;
  logic       op_ready;
  logic [7:0] r0 = '0, pc_ret = '0;
  logic [7:0] mem_addr, mem_wdata, mem_rdata, pop_data, sp;
  logic       mem_we, mem_re, done, err, pc_load, empty, full;

  logic [7:0] ram [256];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stack_op_sequencer dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .op_ready(op_ready),
    .r0(r0), .pc_ret(pc_ret), .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .done(done), .err(err),
    .pop_data(pop_data), .pc_load(pc_load), .sp(sp), .empty(empty), .full(full)
  );

  // Read data valid one cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns 1ns after the accepting edge T.
  task automatic issue(input logic [1:0] o, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    op = o; r0 = d; pc_ret = d; op_valid = 1'b1;
    while (!op_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) check("accept_timeout", 32'(op_ready), 1);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  initial begin
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(op_ready), 1);
    check("rst_sp", 32'(sp), 32'hFF);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pop_data", 32'(pop_data), 0);
    check("rst_addr", 32'(mem_addr), 0);

    // 1: single push
    issue(OP_PUSH, 8'hFA);
    step();
    check("push_we", 32'(mem_we), 1);
    check("push_addr", 32'(mem_addr), 32'hFF);
    check("push_wdata", 32'(mem_wdata), 32'hFA);
    check("push_done", 32'(done), 1);
    check("push_err", 32'(err), 0);
    check("push_sp", 32'(sp), 32'hFE);
    check("push_empty", 32'(empty), 0);
    step();
    check("push_idle_ready", 32'(op_ready), 1);
    check("push_done_pulse", 32'(done), 0);

    // 2: pop it back
    issue(OP_POP, 8'h00);
    step();
    check("pop_re", 32'(mem_re), 1);
    check("pop_addr", 32'(mem_addr), 32'hFF);
    check("pop_sp", 32'(sp), 32'hFF);
    check("pop_empty", 32'(empty), 1);
    check("pop_early_done", 32'(done), 0);
    step();
    check("pop_re_pulse", 32'(mem_re), 0);
    step();
    check("pop_done", 32'(done), 1);
    check("pop_data", 32'(pop_data), 32'hFA);
    check("pop_pc_load", 32'(pc_load), 0);
    check("pop_err", 32'(err), 0);

    // 3: underflow
    issue(OP_POP, 8'h00);
    step();
    check("uflow_done", 32'(done), 1);
    check("uflow_err", 32'(err), 1);
    check("uflow_re", 32'(mem_re), 0);
    check("uflow_sp", 32'(sp), 32'hFF);
    step();
    check("uflow_ready", 32'(op_ready), 1);

    // 4: fill to DEPTH, overflow, drain in LIFO order
    for (int i = 0; i < 16; i++) begin
      issue(OP_PUSH, 8'(i));
      step();
    end
    check("fill_full", 32'(full), 1);
    check("fill_sp", 32'(sp), 32'hEF);
    issue(OP_PUSH, 8'h55);
    step();
    check("oflow_done", 32'(done), 1);
    check("oflow_err", 32'(err), 1);
    check("oflow_we", 32'(mem_we), 0);
    check("oflow_sp", 32'(sp), 32'hEF);
    for (int i = 0; i < 16; i++) begin
      issue(OP_POP, 8'h00);
      repeat (3) step();
      check($sformatf("drain_%0d", i), 32'(pop_data), 32'(15 - i));
    end
    check("drain_empty", 32'(empty), 1);
    check("drain_sp", 32'(sp), 32'hFF);

    // 5: CALL/RET
    issue(OP_CALL, 8'h3C);
    step();
    check("call_we", 32'(mem_we), 1);
    check("call_wdata", 32'(mem_wdata), 32'h3C);
    issue(OP_RET, 8'h00);
    repeat (3) step();
    check("ret_done", 32'(done), 1);
    check("ret_data", 32'(pop_data), 32'h3C);
    check("ret_pc_load", 32'(pc_load), 1);
    check("ret_err", 32'(err), 0);

    // Request held valid while busy is taken on the first idle cycle.
    issue(OP_PUSH, 8'h11);
    op = OP_POP; op_valid = 1'b1;
    step();
    check("b2b_push_done", 32'(done), 1);
    step();
    op_valid = 1'b0;
    check("b2b_busy", 32'(op_ready), 0);
    step();
    check("b2b_re", 32'(mem_re), 1);
    check("b2b_addr", 32'(mem_addr), 32'hFF);
    repeat (2) step();
    check("b2b_data", 32'(pop_data), 32'h11);

    // 6: reset in the RD cycle aborts the pop
    issue(OP_PUSH, 8'hAA);
    step();
    issue(OP_POP, 8'h00);
    rst = 1'b1;
    step();
    check("abort_re", 32'(mem_re), 0);
    check("abort_sp", 32'(sp), 32'hFF);
    check("abort_empty", 32'(empty), 1);
    check("abort_done", 32'(done), 0);
    check("abort_ready", 32'(op_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("abort_no_re", 32'(mem_re), 0);
    issue(OP_POP, 8'h00);
    step();
    check("abort_count0_err", 32'(err), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
